// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master: FSM states, R/W codes, quarter phases,
// and the per-state bus level table used to drive SCL/SDA.
package i2c_pkg;

   localparam int I2C_BITS = 8;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      AACK,
      WDATA,
      WACK,
      RDATA,
      RACK,
      STOP
   } state_t;

   typedef struct packed {
      logic scl;
      logic sda_low;
   } bus_lvl_t;

   // SCL/SDA levels for a given state and quarter; sda_low = 1 pulls the bus low.
   function automatic bus_lvl_t bus_levels(state_t st, logic [1:0] ph, logic tx_bit);
      bus_lvl_t lvl;
      lvl.scl     = (ph == Q2) || (ph == Q3);
      lvl.sda_low = 1'b0;
      case (st)
         IDLE: lvl.scl = 1'b1;
         START: begin
            lvl.scl     = 1'b1;
            lvl.sda_low = (ph == Q2) || (ph == Q3);
         end
         ADDR, WDATA: lvl.sda_low = !tx_bit;
         STOP: begin
            lvl.scl     = (ph != Q0);
            lvl.sda_low = (ph == Q0) || (ph == Q1);
         end
         default: ;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Command/status bundle between the CPU side and the I2C master.
// The requester uses the master modport; the I2C block uses the slave modport.
interface i2c_master_if;
   import i2c_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [6:0]          cmd_addr;
   logic                cmd_rw;
   logic [I2C_BITS-1:0] cmd_wdata;
   logic                busy;
   logic                done;
   logic [I2C_BITS-1:0] rdata;
   logic                ack_error;

   modport master (
      output cmd_valid, cmd_addr, cmd_rw, cmd_wdata,
      input  cmd_ready, busy, done, rdata, ack_error
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata,
      output cmd_ready, busy, done, rdata, ack_error
   );

endinterface

// File: rtl/i2c_clk_gen.sv
// Quarter-period timer: counts CLK_DIV clks per quarter, pulses qtick on the last clk
// of each quarter and advances the 2-bit phase. Held at phase Q0 while clear is high.
module i2c_clk_gen
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   output logic       qtick,
   output logic [1:0] phase,
   output logic [1:0] phase_next
);

   localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_reg, cnt_next;
   logic [1:0]    phase_reg;

   always_comb begin
      qtick      = (cnt_reg == CNT_MAX);
      cnt_next   = qtick ? '0 : cnt_reg + 1'b1;
      phase_next = qtick ? phase_reg + 2'd1 : phase_reg;
      if (clear) begin
         cnt_next   = '0;
         phase_next = Q0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg   <= '0;
         phase_reg <= Q0;
      end else begin
         cnt_reg   <= cnt_next;
         phase_reg <= phase_next;
      end
   end

   assign phase = phase_reg;

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: turns one command into a START/address/data/STOP frame.
// Bus levels are registered from next-state values so SCL/SDA leave the block glitch-free.
module i2c_master
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 5
) (
   input  logic        clk,
   input  logic        reset,
   i2c_master_if.slave bus,
   output logic        scl,
   inout  wire         sda
);

   localparam logic [2:0] LAST_BIT = 3'(I2C_BITS - 1);

   state_t               state_reg, state_next;
   logic [2:0]           bit_cnt_reg, bit_cnt_next;
   logic [I2C_BITS-1:0]  shift_reg, shift_next;
   logic [I2C_BITS-1:0]  wdata_reg, wdata_next;
   logic [I2C_BITS-1:0]  rdata_reg, rdata_next;
   logic                 rw_reg, rw_next;
   logic                 sda_smp_reg, sda_smp_next;
   logic                 ack_error_reg, ack_error_next;
   logic                 done_reg, done_next;
   logic                 scl_reg, sda_low_reg;
   logic                 qtick, bit_end, smp;
   logic [1:0]           phase, phase_next;
   bus_lvl_t             lvl_next;

   i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk        (clk),
      .reset      (reset),
      .clear      (state_reg == IDLE),
      .qtick      (qtick),
      .phase      (phase),
      .phase_next (phase_next)
   );

   assign bit_end = qtick && (phase == Q3);
   assign smp     = qtick && (phase == Q2);

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      wdata_next     = wdata_reg;
      rdata_next     = rdata_reg;
      rw_next        = rw_reg;
      sda_smp_next   = smp ? sda : sda_smp_reg;
      ack_error_next = ack_error_reg;
      done_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.cmd_valid) begin
               state_next     = START;
               shift_next     = {bus.cmd_addr, bus.cmd_rw};
               wdata_next     = bus.cmd_wdata;
               rw_next        = bus.cmd_rw;
               bit_cnt_next   = '0;
               ack_error_next = 1'b0;
            end
         end
         START: if (bit_end) state_next = ADDR;
         ADDR, WDATA: begin
            if (bit_end) begin
               shift_next   = {shift_reg[I2C_BITS-2:0], 1'b0};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == LAST_BIT) state_next = (state_reg == ADDR) ? AACK : WACK;
            end
         end
         AACK: begin
            if (bit_end) begin
               if (sda_smp_reg) begin
                  ack_error_next = 1'b1;
                  state_next     = STOP;
               end else if (rw_reg == RW_READ) begin
                  state_next = RDATA;
               end else begin
                  state_next = WDATA;
                  shift_next = wdata_reg;
               end
            end
         end
         WACK: begin
            if (bit_end) begin
               if (sda_smp_reg) ack_error_next = 1'b1;
               state_next = STOP;
            end
         end
         RDATA: begin
            // Read bits enter on the sample point, not the bit boundary.
            if (smp) shift_next = {shift_reg[I2C_BITS-2:0], sda};
            if (bit_end) begin
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == LAST_BIT) state_next = RACK;
            end
         end
         RACK: begin
            if (bit_end) begin
               rdata_next = shift_reg;
               state_next = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      lvl_next = bus_levels(state_next, phase_next, shift_next[I2C_BITS-1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         wdata_reg     <= '0;
         rdata_reg     <= '0;
         rw_reg        <= 1'b0;
         sda_smp_reg   <= 1'b1;
         ack_error_reg <= 1'b0;
         done_reg      <= 1'b0;
         scl_reg       <= 1'b1;
         sda_low_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         wdata_reg     <= wdata_next;
         rdata_reg     <= rdata_next;
         rw_reg        <= rw_next;
         sda_smp_reg   <= sda_smp_next;
         ack_error_reg <= ack_error_next;
         done_reg      <= done_next;
         scl_reg       <= lvl_next.scl;
         sda_low_reg   <= lvl_next.sda_low;
      end
   end

   assign scl           = scl_reg;
   assign sda           = sda_low_reg ? 1'b0 : 1'bz;
   assign bus.cmd_ready = (state_reg == IDLE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.done      = done_reg;
   assign bus.rdata     = rdata_reg;
   assign bus.ack_error = ack_error_reg;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: two instances (CLK_DIV 5 and 1), each with a behavioural I2C slave
// at 0x6A and a START/STOP monitor; results are compared against frame-level expectations.
module tb_i2c_master;
   import i2c_pkg::*;

   localparam int         NB       = 2;
   localparam logic [6:0] SLV_ADDR = 7'h6A;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   logic [NB-1:0] cmd_valid;
   logic [NB-1:0] cmd_rw;
   logic [6:0]    cmd_addr  [NB];
   logic [7:0]    cmd_wdata [NB];
   logic [7:0]    slave_din [NB];
   logic [7:0]    exp_rdata [NB];

   wire [NB-1:0]        ready_w, busy_w, done_w, ackerr_w, scl_w, sda_w, mack_w;
   wire [NB-1:0][7:0]   rdata_w, sdout_w;
   wire [NB-1:0][31:0]  nstart_w, nstop_w, ndready_w;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_bus
         i2c_master_if ifc();
         wire  sda;
         wire  scl;
         pullup (sda);

         logic       s_drive_low = 1'b0;
         logic       scl_p = 1'b1;
         logic       sda_p = 1'b1;
         logic [7:0] s_shift = '0;
         logic [7:0] s_tx = '0;
         logic [7:0] s_dout = '0;
         logic       s_rw = 1'b0;
         logic       s_mack = 1'b0;
         int         s_bits = 0;
         int         s_mode = 0;
         int         n_start = 0;
         int         n_stop = 0;
         int         n_dready = 0;

         assign sda           = s_drive_low ? 1'b0 : 1'bz;
         assign ifc.cmd_valid = cmd_valid[gi];
         assign ifc.cmd_addr  = cmd_addr[gi];
         assign ifc.cmd_rw    = cmd_rw[gi];
         assign ifc.cmd_wdata = cmd_wdata[gi];

         i2c_master #(.CLK_DIV((gi == 0) ? 5 : 1)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (ifc),
            .scl   (scl),
            .sda   (sda)
         );

         assign ready_w[gi]   = ifc.cmd_ready;
         assign busy_w[gi]    = ifc.busy;
         assign done_w[gi]    = ifc.done;
         assign ackerr_w[gi]  = ifc.ack_error;
         assign rdata_w[gi]   = ifc.rdata;
         assign scl_w[gi]     = scl;
         assign sda_w[gi]     = sda;
         assign sdout_w[gi]   = s_dout;
         assign mack_w[gi]    = s_mack;
         assign nstart_w[gi]  = n_start;
         assign nstop_w[gi]   = n_stop;
         assign ndready_w[gi] = n_dready;

         // Slave modes: 0 idle, 1 addr, 2 addr ack, 3 wdata, 4 data ack, 5 rdata, 6 master ack, 7 wait stop.
         always @(negedge clk) begin
            scl_p <= scl;
            sda_p <= sda;
            if (reset) begin
               s_mode      <= 0;
               s_drive_low <= 1'b0;
            end else if (scl_p && scl && sda_p && !sda) begin
               n_start     <= n_start + 1;
               s_mode      <= 1;
               s_bits      <= 0;
               s_drive_low <= 1'b0;
               s_mack      <= 1'b0;
            end else if (scl_p && scl && !sda_p && sda) begin
               n_stop      <= n_stop + 1;
               s_mode      <= 0;
               s_drive_low <= 1'b0;
            end else if (!scl_p && scl) begin
               if (s_mode == 1 || s_mode == 3) begin
                  s_shift <= {s_shift[6:0], sda};
                  s_bits  <= s_bits + 1;
               end else if (s_mode == 6) begin
                  s_mack <= sda;
               end
            end else if (scl_p && !scl) begin
               case (s_mode)
                  1: if (s_bits == 8) begin
                     if (s_shift[7:1] == SLV_ADDR) begin
                        s_drive_low <= 1'b1;
                        s_rw        <= s_shift[0];
                        s_mode      <= 2;
                     end else begin
                        s_mode <= 0;
                     end
                  end
                  2: if (s_rw) begin
                     s_tx        <= slave_din[gi];
                     s_drive_low <= !slave_din[gi][7];
                     s_bits      <= 1;
                     s_mode      <= 5;
                  end else begin
                     s_drive_low <= 1'b0;
                     s_bits      <= 0;
                     s_mode      <= 3;
                  end
                  3: if (s_bits == 8) begin
                     s_dout      <= s_shift;
                     n_dready    <= n_dready + 1;
                     s_drive_low <= 1'b1;
                     s_mode      <= 4;
                  end
                  4: begin
                     s_drive_low <= 1'b0;
                     s_mode      <= 7;
                  end
                  5: if (s_bits == 8) begin
                     s_drive_low <= 1'b0;
                     s_mode      <= 6;
                  end else begin
                     s_drive_low <= !s_tx[3'(7 - s_bits)];
                     s_bits      <= s_bits + 1;
                  end
                  6: s_mode <= 7;
                  default: ;
               endcase
            end
         end
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after a clock edge; returns #1 after the acceptance edge with cmd_valid still high.
   task automatic accept(input int b, input logic [6:0] a, input logic rw, input logic [7:0] wd);
      int n = 0;
      cmd_addr[b]  = a;
      cmd_rw[b]    = rw;
      cmd_wdata[b] = wd;
      cmd_valid[b] = 1'b1;
      while (!ready_w[b] && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("ready_wait", 32'(ready_w[b]), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int b, output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!done_w[b] && lat < 2000);
   endtask

   task automatic xact(input int b, input logic [6:0] a, input logic rw,
                       input logic [7:0] wd, input logic [7:0] sd);
      int lat, st0, sp0, dr0, div;
      bit acked;
      div          = (b == 0) ? 5 : 1;
      acked        = (a == SLV_ADDR);
      slave_din[b] = sd;
      st0          = nstart_w[b];
      sp0          = nstop_w[b];
      dr0          = ndready_w[b];
      accept(b, a, rw, wd);
      cmd_valid[b] = 1'b0;
      check("busy_after_accept", 32'(busy_w[b]), 32'd1);
      check("ready_after_accept", 32'(ready_w[b]), 32'd0);
      wait_done(b, lat);
      if (acked && rw == RW_READ) exp_rdata[b] = sd;
      check("frame_length", 32'(lat), 32'(div * (acked ? 80 : 44)));
      check("ack_error", 32'(ackerr_w[b]), 32'(!acked));
      check("rdata", 32'(rdata_w[b]), 32'(exp_rdata[b]));
      check("start_count", 32'(nstart_w[b] - st0), 32'd1);
      check("stop_count", 32'(nstop_w[b] - sp0), 32'd1);
      if (acked && rw == RW_WRITE) begin
         check("slave_data_out", 32'(sdout_w[b]), 32'(wd));
         check("slave_data_ready", 32'(ndready_w[b] - dr0), 32'd1);
      end else begin
         check("slave_no_data_ready", 32'(ndready_w[b] - dr0), 32'd0);
      end
      if (acked && rw == RW_READ) check("master_nack", 32'(mack_w[b]), 32'd1);
      $display("[TB] xact bus=%0d addr=0x%02h rw=%0d wdata=0x%02h lat=%0d ack_error=%0d rdata=0x%02h",
               b, a, rw, wd, lat, ackerr_w[b], rdata_w[b]);
   endtask

   initial begin
      int         lat, st0, sp0;
      bit         seen_done;
      logic [7:0] w1, d1;
      logic [6:0] ra;
      cmd_valid = '0;
      cmd_rw    = '0;
      for (int i = 0; i < NB; i++) begin
         cmd_addr[i]  = '0;
         cmd_wdata[i] = '0;
         slave_din[i] = '0;
         exp_rdata[i] = '0;
      end

      repeat (3) @(posedge clk);
      #1;
      for (int b = 0; b < NB; b++) begin
         check("rst_scl", 32'(scl_w[b]), 32'd1);
         check("rst_sda_released", 32'(sda_w[b]), 32'd1);
         check("rst_ready", 32'(ready_w[b]), 32'd1);
         check("rst_busy", 32'(busy_w[b]), 32'd0);
         check("rst_done", 32'(done_w[b]), 32'd0);
         check("rst_rdata", 32'(rdata_w[b]), 32'd0);
         check("rst_ack_error", 32'(ackerr_w[b]), 32'd0);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Directed write, read, address NACK.
      xact(0, SLV_ADDR, RW_WRITE, 8'hAA, 8'h00);
      xact(0, SLV_ADDR, RW_READ, 8'h00, 8'hCC);
      xact(0, 7'h55, RW_WRITE, 8'h12, 8'h00);

      // Back-to-back write then read with cmd_valid held.
      w1           = 8'($urandom);
      d1           = 8'($urandom);
      slave_din[0] = d1;
      st0          = nstart_w[0];
      sp0          = nstop_w[0];
      accept(0, SLV_ADDR, RW_WRITE, w1);
      cmd_rw[0] = RW_READ;
      wait_done(0, lat);
      check("b2b_first_length", 32'(lat), 32'd400);
      check("b2b_ready_with_done", 32'(ready_w[0]), 32'd1);
      check("b2b_write_data", 32'(sdout_w[0]), 32'(w1));
      @(posedge clk);
      #1;
      cmd_valid[0] = 1'b0;
      check("b2b_second_accepted", 32'(ready_w[0]), 32'd0);
      wait_done(0, lat);
      exp_rdata[0] = d1;
      check("b2b_second_length", 32'(lat), 32'd400);
      check("b2b_rdata", 32'(rdata_w[0]), 32'(d1));
      check("b2b_starts", 32'(nstart_w[0] - st0), 32'd2);
      check("b2b_stops", 32'(nstop_w[0] - sp0), 32'd2);
      $display("[TB] xact bus=0 back-to-back write=0x%02h read=0x%02h", w1, rdata_w[0]);

      // Reset during WDATA bit 3 (quarter 52 of the frame at CLK_DIV 5).
      sp0 = nstop_w[0];
      accept(0, SLV_ADDR, RW_WRITE, 8'h5A);
      cmd_valid[0] = 1'b0;
      repeat (261) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < NB; i++) exp_rdata[i] = '0;
      check("abort_scl", 32'(scl_w[0]), 32'd1);
      check("abort_sda_released", 32'(sda_w[0]), 32'd1);
      check("abort_ready", 32'(ready_w[0]), 32'd1);
      check("abort_done", 32'(done_w[0]), 32'd0);
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done_w[0]) seen_done = 1'b1;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      check("abort_no_stop", 32'(nstop_w[0] - sp0), 32'd0);
      $display("[TB] xact bus=0 reset mid-frame, bus released");
      xact(0, SLV_ADDR, RW_WRITE, 8'h3C, 8'h00);

      // CLK_DIV = 1 instance.
      xact(1, SLV_ADDR, RW_WRITE, 8'hAA, 8'h00);
      xact(1, SLV_ADDR, RW_READ, 8'h00, 8'h96);
      xact(1, 7'h55, RW_READ, 8'h00, 8'h11);

      // Randomized commands on either instance.
      for (int k = 0; k < 10; k++) begin
         int b;
         b  = int'($urandom_range(0, 1));
         ra = SLV_ADDR;
         if ($urandom_range(0, 3) == 0) begin
            ra = 7'($urandom);
            if (ra == SLV_ADDR) ra = ra ^ 7'h01;
         end
         xact(b, ra, 1'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
